// File: rtl/input_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_pkg
// Description : Shared types, default timing constants (74.25 MHz clock) and
//               the counter width helper for the input debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package input_debounce_pkg;

  // Auto-repeat state per channel
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // ~0.88 ms of stability before a level change is accepted
  localparam int c_DEBOUNCE_CYCLES = 65536;
  // ~323 ms hold before the first auto-repeat
  localparam int c_REPEAT_DELAY    = 24000000;
  // ~54 ms between subsequent auto-repeats
  localparam int c_REPEAT_RATE     = 4000000;

  // Bits needed to hold values 0..max_count; never less than one bit
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : Single-bit debouncer. Accepts a level change after
//               DEBOUNCE_CYCLES consecutive differing samples and emits
//               one-cycle press/release pulses. When INPUT_DEBOUNCE_REPEAT_EN
//               is defined, a held press also produces auto-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
  parameter int REPEAT_RATE     = c_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int              c_CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic [c_CW-1:0] r_cnt;
  logic            r_dout;
  logic            r_press;
  logic            r_release;
  logic            w_toggle;

  // Input has disagreed with the accepted level for the full window
  assign w_toggle = (din != r_dout) && (r_cnt == c_LAST);

  // Stability counter, accepted level and edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_dout    <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_toggle && !r_dout;
      r_release <= w_toggle &&  r_dout;
      if (din == r_dout) begin
        r_cnt <= '0;
      end else if (w_toggle) begin
        r_cnt  <= '0;
        r_dout <= ~r_dout;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout          = r_dout;
  assign press         = r_press;
  assign release_pulse = r_release;

`ifdef INPUT_DEBOUNCE_REPEAT_EN
  localparam int c_RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int c_RW   = cnt_width(c_RMAX);
  localparam logic [c_RW-1:0] c_DELAY_LAST = c_RW'(REPEAT_DELAY - 1);
  localparam logic [c_RW-1:0] c_RATE_LAST  = c_RW'(REPEAT_RATE - 1);

  rpt_state_t      r_state;
  logic [c_RW-1:0] r_rcnt;
  logic            r_repeat;
  logic            w_rise;
  logic            w_fall;

  // Decoded on the same edge that updates dout, so the FSM tracks press/release exactly
  assign w_rise = w_toggle && !r_dout;
  assign w_fall = w_toggle &&  r_dout;

  // Auto-repeat FSM; a debounced release wins over any pending repeat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (w_fall) begin
        r_state <= IDLE;
        r_rcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_state <= DELAY;
              r_rcnt  <= '0;
            end
          end
          DELAY: begin
            if (r_rcnt == c_DELAY_LAST) begin
              r_repeat <= 1'b1;
              r_rcnt   <= '0;
              r_state  <= REPEAT;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
          REPEAT: begin
            if (r_rcnt == c_RATE_LAST) begin
              r_repeat <= 1'b1;
              r_rcnt   <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_rcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : WIDTH independent debounce channels for synchronized slow
//               inputs (buttons). Outputs a clean level plus one-cycle
//               press/release pulses per bit. Optional auto-repeat is built
//               when the macro INPUT_DEBOUNCE_REPEAT_EN is defined; otherwise
//               repeat_pulse is constant zero.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
  parameter int REPEAT_RATE     = c_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] repeat_pulse
);

  // One fully independent channel per input bit
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
      ) u_chan (
        .clk           (clk),
        .reset         (reset),
        .din           (din[gi]),
        .dout          (dout[gi]),
        .press         (press[gi]),
        .release_pulse (release_pulse[gi]),
        .repeat_pulse  (repeat_pulse[gi])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debounce
// Description : Directed self-checking bench for input_debounce
//               (WIDTH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce;

  localparam int c_W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [c_W-1:0] din;
  logic [c_W-1:0] dout;
  logic [c_W-1:0] press;
  logic [c_W-1:0] release_pulse;
  logic [c_W-1:0] repeat_pulse;

  int n_vec  = 0;
  int n_fail = 0;

  input_debounce #(
    .WIDTH           (c_W),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .din           (din),
    .dout          (dout),
    .press         (press),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge

  task automatic test_reset();
    reset = 1'b1;
    din   = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({dout, press, release_pulse, repeat_pulse} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got dout=%b press=%b rel=%b rpt=%b, want all 0",
               dout, press, release_pulse, repeat_pulse);
    end
    reset = 1'b0;
  endtask

  task automatic test_press();
    logic [c_W-1:0] exp_press;
    din = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_press = (k == 4) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (dout !== ((k >= 4) ? 4'b0001 : 4'b0000) || press !== exp_press ||
          release_pulse !== 4'b0000 || repeat_pulse !== 4'b0000) begin
        n_fail++;
        $display("FAIL press k=%0d: got dout=%b press=%b rel=%b rpt=%b, want dout=%b press=%b rel=0000 rpt=0000",
                 k, dout, press, release_pulse, repeat_pulse,
                 (k >= 4) ? 4'b0001 : 4'b0000, exp_press);
      end
    end
  endtask

  task automatic test_glitch();
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 5; k++) begin
        din = (k < 3) ? 4'b0011 : 4'b0001;
        @(negedge clk);
        n_vec++;
        if (dout[1] !== 1'b0 || press !== 4'b0000 || release_pulse !== 4'b0000 ||
            repeat_pulse[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch p=%0d k=%0d: got dout=%b press=%b rel=%b rpt1=%b, want dout[1]=0 press=0000 rel=0000 rpt1=0",
                   p, k, dout, press, release_pulse, repeat_pulse[1]);
        end
      end
    end
  endtask

  task automatic test_release();
    logic [c_W-1:0] exp_rel;
    din = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_rel = (k == 4) ? 4'b0001 : 4'b0000;
      n_vec++;
      if (dout !== ((k < 4) ? 4'b0001 : 4'b0000) || release_pulse !== exp_rel ||
          press !== 4'b0000 || (k >= 4 && repeat_pulse !== 4'b0000)) begin
        n_fail++;
        $display("FAIL release k=%0d: got dout=%b press=%b rel=%b rpt=%b, want dout=%b press=0000 rel=%b",
                 k, dout, press, release_pulse, repeat_pulse,
                 (k < 4) ? 4'b0001 : 4'b0000, exp_rel);
      end
    end
  endtask

  task automatic test_all_bits();
    logic [c_W-1:0] exp_dout;
    logic [c_W-1:0] exp_rel;
    din = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (press !== ((k == 4) ? 4'b1111 : 4'b0000) ||
          dout !== ((k >= 4) ? 4'b1111 : 4'b0000)) begin
        n_fail++;
        $display("FAIL all_press k=%0d: got dout=%b press=%b, want dout=%b press=%b",
                 k, dout, press, (k >= 4) ? 4'b1111 : 4'b0000,
                 (k == 4) ? 4'b1111 : 4'b0000);
      end
    end
    // Staggered release: bit0 now, bit1 two cycles later
    din = 4'b1110;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_dout = (k < 4) ? 4'b1111 : (k < 6) ? 4'b1110 : 4'b1100;
      exp_rel  = (k == 4) ? 4'b0001 : (k == 6) ? 4'b0010 : 4'b0000;
      n_vec++;
      if (dout !== exp_dout || release_pulse !== exp_rel || press !== 4'b0000) begin
        n_fail++;
        $display("FAIL stagger k=%0d: got dout=%b rel=%b press=%b, want dout=%b rel=%b press=0000",
                 k, dout, release_pulse, press, exp_dout, exp_rel);
      end
      if (k == 2) din = 4'b1100;
    end
    din = 4'b0000;
    repeat (6) @(negedge clk);
    n_vec++;
    if (dout !== 4'b0000) begin
      n_fail++;
      $display("FAIL all_clear: got dout=%b, want 0000", dout);
    end
  endtask

  task automatic test_reset_mid();
    din = 4'b0100;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (dout !== 4'b0000 || press !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got dout=%b press=%b, want 0000 0000", dout, press);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (dout !== ((k >= 4) ? 4'b0100 : 4'b0000) ||
          press !== ((k == 4) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d: got dout=%b press=%b, want dout=%b press=%b",
                 k, dout, press, (k >= 4) ? 4'b0100 : 4'b0000,
                 (k == 4) ? 4'b0100 : 4'b0000);
      end
    end
    din = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_repeat();
    logic [c_W-1:0] exp_rpt;
    din = 4'b1000;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
`ifdef INPUT_DEBOUNCE_REPEAT_EN
      exp_rpt = (k >= 14 && k <= 28 && ((k - 14) % 3) == 0) ? 4'b1000 : 4'b0000;
`else
      exp_rpt = 4'b0000;
`endif
      n_vec++;
      if (repeat_pulse !== exp_rpt ||
          press !== ((k == 4) ? 4'b1000 : 4'b0000) ||
          release_pulse !== ((k == 29) ? 4'b1000 : 4'b0000)) begin
        n_fail++;
        $display("FAIL repeat k=%0d: got rpt=%b press=%b rel=%b, want rpt=%b press=%b rel=%b",
                 k, repeat_pulse, press, release_pulse, exp_rpt,
                 (k == 4) ? 4'b1000 : 4'b0000, (k == 29) ? 4'b1000 : 4'b0000);
      end
      if (k == 25) din = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_release();
    test_all_bits();
    test_reset_mid();
    test_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_debounce.md
Name: input_debounce

Overview:
- Per-bit debouncer and edge qualifier for controller buttons and other slow digital inputs.
- Sits directly downstream of the 2-stage synchronizer. Its input is already synchronous to clk.
- Produces a glitch-free level per bit plus one-cycle press and release pulses for core logic and menus.
- Each bit is handled by an independent channel instance.

Parameters:
- WIDTH, 16, number of independent input channels.
- DEBOUNCE_CYCLES, 65536, consecutive stable cycles required before a level change is accepted. Must be >= 1.
- REPEAT_DELAY, 24000000, cycles a press must be held before the first repeat pulse. Used only with the optional feature.
- REPEAT_RATE, 4000000, cycles between subsequent repeat pulses. Used only with the optional feature.

Ports:
- clk  input  1  single clock; everything is in this domain.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  synchronized raw inputs.
- dout  output  WIDTH  debounced level.
- press  output  WIDTH  one-cycle pulse when dout rises.
- release  output  WIDTH  one-cycle pulse when dout falls.
- repeat  output  WIDTH  one-cycle auto-repeat pulse; constant 0 when the optional feature is compiled out.

Behaviour:
- Interface (decided): one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values: dout=0, press=0, release=0, repeat=0, all counters 0, repeat FSM = IDLE. All outputs are registered.
- Stability counter, per channel:
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - If din[i]==dout[i], the counter clears to 0.
  - If din[i]!=dout[i] and the counter is below DEBOUNCE_CYCLES-1, the counter increments.
  - If din[i]!=dout[i] and the counter equals DEBOUNCE_CYCLES-1: dout[i] toggles next edge, the counter clears, and press[i] or release[i] asserts for exactly that same cycle.
- Latency: dout changes DEBOUNCE_CYCLES clocks after the first differing sample, provided din is held. With DEBOUNCE_CYCLES=1, dout equals din delayed by one clock.
- Glitch handling: any sample equal to dout restarts the count from 0. Shorter glitches produce no output activity.
- Simultaneity:
  - Channels are fully independent; any combination of pulses may assert in the same cycle.
  - press and release never assert together on one bit.
- Reset mid-count: the partial count is discarded.
- Input held high through reset release: dout=0 after reset, so a press pulse follows DEBOUNCE_CYCLES cycles after release. This is intended.
- Counter saturation is impossible: the counter wraps to 0 only via a toggle or a clear.

Optional Feature:
- Macro: INPUT_DEBOUNCE_REPEAT_EN.
- Defined: each channel adds a repeat FSM with states IDLE, DELAY and REPEAT, plus a counter of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - IDLE -> DELAY on press[i]; the counter loads 0.
  - DELAY: the counter increments. At REPEAT_DELAY-1, repeat[i] pulses, the counter clears and the FSM moves to REPEAT.
  - REPEAT: at REPEAT_RATE-1, repeat[i] pulses and the counter clears.
  - Debounced release (dout[i] falling) forces IDLE from any state on that same edge. No repeat pulse occurs in the release cycle.
  - repeat never coincides with press on the same bit.
- Undefined: no repeat FSM or counters are synthesized. The repeat port is driven to 0.

Decomposition:
- Package input_debounce_pkg holds:
  - the repeat FSM state typedef (enum logic [1:0] IDLE/DELAY/REPEAT);
  - the default DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE constants, for 74.25 MHz;
  - a function computing counter width.
- One sub-module: debounce_channel, a single-bit channel with counter, pulses and optional repeat FSM.
- The top generates WIDTH instances.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3):
- Reset then hold din=4'b0001 -> dout[0] rises 4 clocks after the first sample. press=4'b0001 for exactly one cycle. release and repeat stay 0.
- din[1] high for 3 cycles then low, repeated 5 times -> dout[1], press[1] and release[1] never assert.
- din[0] high then low after dout settles -> release[0] pulses once, 4 clocks after the fall. No press in the same cycle.
- din=4'b1111 applied in one cycle -> press=4'b1111 in a single cycle 4 clocks later. Counters are independent when bits are later released at different times.
- Assert reset for 1 cycle while a count is at 2 with din[2]=1 -> after reset, dout[2] rises exactly 4 clocks later and press[2] pulses.
- With INPUT_DEBOUNCE_REPEAT_EN: hold din[3] -> repeat[3] at press+10, then every 3 cycles. Release -> repeat stops within the release cycle.
- Without INPUT_DEBOUNCE_REPEAT_EN: the same held input gives repeat=0 throughout.
